// File: rtl/dma_fifo_ctrl_if.sv
// Bus bundle for the DMA controller: Avalon-MM read master, write master and FIFO port.
// Valid/ready: a read or write request is taken on any clock edge where its request is high and waitrequest is low.
interface dma_fifo_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] rd_address;
    logic              rd_read;
    logic              rd_waitrequest;
    logic              rd_readdatavalid;
    logic [31:0]       rd_readdata;
    logic [ADDR_W-1:0] wr_address;
    logic              wr_write;
    logic [31:0]       wr_writedata;
    logic              wr_waitrequest;
    logic              FF_writerequest;
    logic [31:0]       FF_data;
    logic              FF_readrequest;
    logic [31:0]       FF_q;
    logic              FF_empty;
    logic              FF_almostfull;

    modport master (
        output rd_address, rd_read,
        input  rd_waitrequest, rd_readdatavalid, rd_readdata,
        output wr_address, wr_write, wr_writedata,
        input  wr_waitrequest,
        output FF_writerequest, FF_data, FF_readrequest,
        input  FF_q, FF_empty, FF_almostfull
    );

    modport slave (
        input  rd_address, rd_read,
        output rd_waitrequest, rd_readdatavalid, rd_readdata,
        input  wr_address, wr_write, wr_writedata,
        output wr_waitrequest,
        input  FF_writerequest, FF_data, FF_readrequest,
        output FF_q, FF_empty, FF_almostfull
    );
endinterface

// File: rtl/dma_fifo_ctrl.sv
// Sequences one memory-to-memory DMA transfer: the read master fills the shared FIFO,
// the write master drains it; reads are credited against the FIFO level so pushes never overflow.
module dma_fifo_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 256,
    parameter int HEADROOM   = 8,
    parameter int MAX_PEND   = 4
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state,
    output logic              dbg_push_af,
    dma_fifo_ctrl_if.master   bus
);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int SUM_W  = LVL_W + 1;
    localparam int CREDIT = FIFO_DEPTH - HEADROOM;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [LEN_W-1:0]  rd_left_q, wr_left_q, rd_left_n;
    logic [PEND_W-1:0] pend_q, pend_n;
    logic [LVL_W-1:0]  lvl_q, lvl_n;
    logic              rd_read_q, rd_read_d;
    logic              rd_acc, push, pop, wr_write_c;
    logic              credit_ok;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_XFER;
            S_XFER:  if (wr_left_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        wr_write_c = 1'b0;
        case (state_q)
            S_XFER: begin
                busy       = 1'b1;
                wr_write_c = !bus.FF_empty && (wr_left_q != '0);
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Returns without an outstanding read are protocol errors and are dropped.
    assign rd_acc    = rd_read_q & ~bus.rd_waitrequest;
    assign push      = bus.rd_readdatavalid & (pend_q != '0);
    assign pop       = wr_write_c & ~bus.wr_waitrequest;
    assign pend_n    = pend_q + PEND_W'(rd_acc) - PEND_W'(push);
    assign lvl_n     = lvl_q + LVL_W'(push) - LVL_W'(pop);
    assign rd_left_n = rd_left_q - LEN_W'(rd_acc);

    // Credit is judged on post-edge counts so a new request can never overcommit the FIFO.
    assign credit_ok = ({1'b0, lvl_n} + SUM_W'(pend_n)) < SUM_W'(CREDIT);
    assign rd_read_d = (rd_read_q & bus.rd_waitrequest) |
                       ((state_q == S_XFER) && (rd_left_n != '0) &&
                        (pend_n < PEND_W'(MAX_PEND)) && credit_ok);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rd_left_q <= '0;
            wr_left_q <= '0;
            pend_q    <= '0;
            lvl_q     <= '0;
            rd_read_q <= 1'b0;
        end else begin
            rd_read_q <= rd_read_d;
            pend_q    <= pend_n;
            lvl_q     <= lvl_n;
            if ((state_q == S_IDLE) && start) begin
                rd_addr_q <= cfg_src;
                wr_addr_q <= cfg_dst;
                rd_left_q <= cfg_len;
                wr_left_q <= cfg_len;
            end else begin
                if (rd_acc) begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(4);
                    rd_left_q <= rd_left_n;
                end
                if (pop) begin
                    wr_addr_q <= wr_addr_q + ADDR_W'(4);
                    wr_left_q <= wr_left_q - LEN_W'(1);
                end
            end
        end
    end

    assign bus.rd_address      = rd_addr_q;
    assign bus.rd_read         = rd_read_q;
    assign bus.wr_address      = wr_addr_q;
    assign bus.wr_write        = wr_write_c;
    assign bus.wr_writedata    = bus.FF_q;
    assign bus.FF_writerequest = push;
    assign bus.FF_data         = bus.rd_readdata;
    assign bus.FF_readrequest  = pop;
    assign dbg_state           = state_q;
    assign dbg_push_af         = push & bus.FF_almostfull;
endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Bench for dma_fifo_ctrl: behavioural FIFO, read slave with in-order random latency,
// write slave with stalls; every write is scored against the source memory image.
module tb_dma_fifo_ctrl;
  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic [31:0] cfg_src = '0, cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        start = 1'b0;
  logic        busy, done, dbg_push_af;
  logic [1:0]  dbg_state;

  always #5 iClk = ~iClk;

  dma_fifo_ctrl_if #(.ADDR_W(32)) bus ();

  dma_fifo_ctrl dut (
    .iClk(iClk), .iReset_n(iReset_n), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len), .start(start), .busy(busy), .done(done),
    .dbg_state(dbg_state), .dbg_push_af(dbg_push_af), .bus(bus)
  );

  int pass_cnt = 0, check_cnt = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] pipe_data[$];
  int          pipe_due[$];
  logic [31:0] exp_q[$], exp_addr_q[$], obs_q[$], obs_addr_q[$];
  int          cyc = 0, last_due = 0, outstanding = 0;
  bit          pend_push = 0, pend_pop = 0;
  logic [31:0] pend_push_data;
  logic [31:0] seed = 32'h1234_5678;

  int wr_stall = 0;
  bit wr_rand = 0, rd_rand = 0, spurious = 0;
  int lat_min = 2, lat_max = 2;

  int max_pend, max_commit, af_viol, push_viol, stall_viol, pop_viol, done_viol;
  int done_cnt, busy_cyc, busy_at_done, rdreq_cyc, wrreq_cyc;
  bit prev_stalled = 0, prev_done = 0;
  logic [31:0] prev_addr;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic void refresh_ff();
    bus.FF_empty      = (fifo_q.size() == 0);
    bus.FF_q          = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    bus.FF_almostfull = (fifo_q.size() >= 248);
  endfunction

  function automatic int sb_mismatch();
    int m = 0;
    if (obs_q.size() != exp_q.size()) return -1;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i] || obs_addr_q[i] !== exp_addr_q[i]) m++;
    return m;
  endfunction

  task automatic clear_stats();
    max_pend = 0; max_commit = 0; af_viol = 0; push_viol = 0; stall_viol = 0;
    pop_viol = 0; done_viol = 0; done_cnt = 0; busy_cyc = 0; busy_at_done = 0;
    rdreq_cyc = 0; wrreq_cyc = 0;
    exp_q.delete(); exp_addr_q.delete(); obs_q.delete(); obs_addr_q.delete();
  endtask

  // Bus/FIFO model: edge+1 apply last cycle's FIFO ops and drive slaves, edge+2 sample.
  initial begin
    bit legit, acc, pop;
    int due, commit;
    bus.rd_waitrequest = 0; bus.rd_readdatavalid = 0; bus.rd_readdata = '0;
    bus.wr_waitrequest = 0;
    refresh_ff();
    forever begin
      @(posedge iClk); #1;
      if (!iReset_n) begin
        fifo_q.delete(); pipe_data.delete(); pipe_due.delete();
        outstanding = 0; last_due = 0; pend_push = 0; pend_pop = 0;
        prev_stalled = 0; prev_done = 0;
        bus.rd_readdatavalid = 0; bus.rd_waitrequest = 0; bus.wr_waitrequest = 0;
        refresh_ff();
      end else begin
        if (pend_pop) void'(fifo_q.pop_front());
        if (pend_push) fifo_q.push_back(pend_push_data);
        pend_pop = 0; pend_push = 0;
        refresh_ff();
        bus.rd_waitrequest = rd_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        if (wr_stall > 0) begin
          bus.wr_waitrequest = 1'b1;
          wr_stall--;
        end else begin
          bus.wr_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        legit = 0;
        if (pipe_due.size() > 0 && pipe_due[0] <= cyc) begin
          legit = 1;
          bus.rd_readdatavalid = 1'b1;
          bus.rd_readdata = pipe_data.pop_front();
          void'(pipe_due.pop_front());
        end else begin
          bus.rd_readdatavalid = spurious;
          bus.rd_readdata = $urandom;
        end
        #1;
        acc = bus.rd_read && !bus.rd_waitrequest;
        if (prev_stalled && (!bus.rd_read || bus.rd_address !== prev_addr)) stall_viol++;
        prev_stalled = bus.rd_read && bus.rd_waitrequest;
        prev_addr = bus.rd_address;
        if (bus.rd_read) rdreq_cyc++;
        if (acc) begin
          due = cyc + $urandom_range(lat_min, lat_max);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pipe_data.push_back(src_word(bus.rd_address));
          pipe_due.push_back(due);
          outstanding++;
        end
        if (legit) outstanding--;
        if (outstanding > max_pend) max_pend = outstanding;
        if (bus.FF_writerequest !== legit) push_viol++;
        if (dbg_push_af !== (bus.FF_writerequest && bus.FF_almostfull)) push_viol++;
        if (bus.FF_writerequest && bus.FF_almostfull) af_viol++;
        pop = bus.wr_write && !bus.wr_waitrequest;
        if (bus.FF_readrequest !== pop) pop_viol++;
        if (bus.wr_write && fifo_q.size() == 0) pop_viol++;
        if (bus.wr_write) wrreq_cyc++;
        if (pop) begin
          obs_q.push_back(bus.wr_writedata);
          obs_addr_q.push_back(bus.wr_address);
        end
        pend_push = bus.FF_writerequest;
        pend_push_data = bus.FF_data;
        pend_pop = pop && (fifo_q.size() > 0);
        commit = fifo_q.size() + int'(pend_push) - int'(pend_pop) + outstanding;
        if (commit > max_commit) max_commit = commit;
        if (busy) busy_cyc++;
        if (done) begin
          done_cnt++;
          busy_at_done = busy_cyc;
          if (!busy) done_viol++;
        end
        if (prev_done && busy) done_viol++;
        prev_done = done;
      end
      cyc++;
    end
  end

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] off;
      off = 32'(i) * 32'd4;
      exp_q.push_back(src_word(s + off));
      exp_addr_q.push_back(d + off);
    end
    @(posedge iClk); #3;
    cfg_src = s; cfg_dst = d; cfg_len = n; start = 1'b1;
    @(posedge iClk); #3;
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int budget, output bit timed_out);
    int d0, k;
    d0 = done_cnt;
    pulse_start(s, d, n);
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge iClk); k++;
    end
    timed_out = (done_cnt == d0);
    @(posedge iClk); #3;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0;
    repeat (3) @(posedge iClk);
    #3;
    check_cnt++;
    if ({busy, done, bus.rd_read, bus.wr_write, bus.FF_writerequest, bus.FF_readrequest, dbg_state} !== 8'h0)
      $display("FAIL reset_ctrl: got %b want 0", {busy, done, bus.rd_read, bus.wr_write,
               bus.FF_writerequest, bus.FF_readrequest, dbg_state});
    else pass_cnt++;
    check_cnt++;
    if ({bus.rd_address, bus.wr_address} !== 64'h0)
      $display("FAIL reset_addr: got %h/%h want 0", bus.rd_address, bus.wr_address);
    else pass_cnt++;
    iReset_n = 1'b1;
    repeat (2) @(posedge iClk);
  endtask

  task automatic test_basic();
    bit to;
    int mm;
    clear_stats(); lat_min = 2; lat_max = 2;
    run_xfer(32'h100, 32'h200, 16'd4, 200, to);
    mm = sb_mismatch();
    check_cnt++;
    if (to) $display("FAIL basic_timeout: done not seen"); else pass_cnt++;
    check_cnt++;
    if (mm !== 0) $display("FAIL basic_data: mismatches %0d (obs %0d words) want 0 of 4", mm, obs_q.size());
    else pass_cnt++;
    check_cnt++;
    if (done_cnt !== 1 || done_viol !== 0)
      $display("FAIL basic_done: pulses %0d viol %0d want 1/0", done_cnt, done_viol);
    else pass_cnt++;
    check_cnt++;
    if (rdreq_cyc !== 4) $display("FAIL basic_rdreq: rd_read cycles %0d want 4", rdreq_cyc);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    bit to;
    clear_stats();
    run_xfer(32'h400, 32'h800, 16'd0, 50, to);
    check_cnt++;
    if (to || busy_cyc !== 2 || busy_at_done !== 2)
      $display("FAIL zero_len_busy: timeout %0d busy %0d done_at %0d want 0/2/2", to, busy_cyc, busy_at_done);
    else pass_cnt++;
    check_cnt++;
    if (rdreq_cyc !== 0 || wrreq_cyc !== 0 || obs_q.size() !== 0)
      $display("FAIL zero_len_bus: rd %0d wr %0d words %0d want 0", rdreq_cyc, wrreq_cyc, obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit to;
    int mm;
    clear_stats(); lat_min = 2; lat_max = 2;
    wr_stall = 400;
    run_xfer(32'h1_0000, 32'h2_0000, 16'd300, 4000, to);
    mm = sb_mismatch();
    check_cnt++;
    if (to) $display("FAIL bp_timeout: done not seen"); else pass_cnt++;
    check_cnt++;
    if (max_commit !== 248) $display("FAIL bp_credit: max lvl+pend %0d want 248", max_commit);
    else pass_cnt++;
    check_cnt++;
    if (af_viol !== 0 || push_viol !== 0)
      $display("FAIL bp_push: almostfull pushes %0d bad pushes %0d want 0", af_viol, push_viol);
    else pass_cnt++;
    check_cnt++;
    if (mm !== 0) $display("FAIL bp_data: mismatches %0d (obs %0d) want 0 of 300", mm, obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_rd_random();
    bit to;
    int mm;
    logic [31:0] s, d;
    logic [15:0] n;
    rd_rand = 1; wr_rand = 1; lat_min = 1; lat_max = 6;
    for (int it = 0; it < 3; it++) begin
      clear_stats();
      s = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      d = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      n = 16'($urandom_range(20, 60));
      run_xfer(s, d, n, 3000, to);
      mm = sb_mismatch();
      check_cnt++;
      if (to || mm !== 0)
        $display("FAIL rand_data[%0d]: timeout %0d mismatches %0d (obs %0d of %0d)", it, to, mm, obs_q.size(), n);
      else pass_cnt++;
      check_cnt++;
      if (max_pend > 4 || stall_viol !== 0 || pop_viol !== 0)
        $display("FAIL rand_proto[%0d]: max_pend %0d stall_viol %0d pop_viol %0d want <=4/0/0",
                 it, max_pend, stall_viol, pop_viol);
      else pass_cnt++;
    end
    rd_rand = 0; wr_rand = 0; lat_min = 2; lat_max = 2;
  endtask

  task automatic test_start_ignored();
    bit to;
    int mm;
    clear_stats(); wr_rand = 1;
    fork
      run_xfer(32'h3000, 32'h5000, 16'd20, 1000, to);
      begin
        repeat (6) @(posedge iClk);
        #3;
        cfg_src = 32'h9000; cfg_dst = 32'hA000; cfg_len = 16'd5; start = 1'b1;
        @(posedge iClk); #3;
        start = 1'b0;
      end
    join
    wr_rand = 0;
    repeat (20) @(posedge iClk);
    #3;
    mm = sb_mismatch();
    check_cnt++;
    if (to || mm !== 0)
      $display("FAIL restart_data: timeout %0d mismatches %0d (obs %0d) want 0 of 20", to, mm, obs_q.size());
    else pass_cnt++;
    check_cnt++;
    if (done_cnt !== 1 || dbg_state !== 2'd0)
      $display("FAIL restart_done: pulses %0d state %0d want 1/0", done_cnt, dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_spurious();
    bit to;
    int mm;
    clear_stats();
    spurious = 1;
    repeat (8) @(posedge iClk);
    spurious = 0;
    @(posedge iClk); #3;
    check_cnt++;
    if (push_viol !== 0) $display("FAIL spurious_push: bad pushes %0d want 0", push_viol);
    else pass_cnt++;
    run_xfer(32'h6000, 32'h7000, 16'd8, 300, to);
    mm = sb_mismatch();
    check_cnt++;
    if (to || mm !== 0)
      $display("FAIL spurious_after: timeout %0d mismatches %0d want 0/0", to, mm);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit to;
    int mm;
    clear_stats();
    run_xfer(32'hFFFF_FFF8, 32'hFFFF_FFF0, 16'd6, 300, to);
    mm = sb_mismatch();
    check_cnt++;
    if (to || mm !== 0)
      $display("FAIL wrap_data: timeout %0d mismatches %0d (obs %0d) want 0 of 6", to, mm, obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    bit to;
    int k, mm;
    clear_stats(); wr_rand = 1;
    pulse_start(32'hB000, 32'hC000, 16'd50);
    k = 0;
    while (obs_q.size() < 20 && k < 500) begin
      @(posedge iClk); k++;
    end
    check_cnt++;
    if (obs_q.size() < 20) $display("FAIL midrst_progress: words %0d want >=20", obs_q.size());
    else pass_cnt++;
    @(posedge iClk); #3;
    iReset_n = 1'b0;
    #1;
    check_cnt++;
    if ({busy, done, bus.rd_read, bus.wr_write, bus.FF_writerequest, bus.FF_readrequest, dbg_state} !== 8'h0)
      $display("FAIL midrst_async: got %b want 0", {busy, done, bus.rd_read, bus.wr_write,
               bus.FF_writerequest, bus.FF_readrequest, dbg_state});
    else pass_cnt++;
    wr_rand = 0;
    repeat (3) @(posedge iClk);
    #3;
    iReset_n = 1'b1;
    repeat (2) @(posedge iClk);
    clear_stats();
    run_xfer(32'hD000, 32'hE000, 16'd3, 200, to);
    mm = sb_mismatch();
    check_cnt++;
    if (to || mm !== 0)
      $display("FAIL midrst_after: timeout %0d mismatches %0d (obs %0d) want 0 of 3", to, mm, obs_q.size());
    else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    seed = $urandom;
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_rd_random();
    test_start_ignored();
    test_spurious();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
